pi_dac_tx: RTL and testbench
============================

PI_DAC_TX -- requirements
Module: pi_dac_tx

Interface
REQ-001 Parameter: CLK_DIV, default 2, clk cycles per sclk half-period (>=1).
REQ-002 Parameter: GAP_CYC, default 2, clk cycles dac_sync_n held high between frames (>=1).
REQ-003 Parameter: OFFSET_BIN, default 1; 1 = offset-binary output code, 0 = two's-complement output code.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 pi_in  input  24  compensation sample, sign-magnitude: bit 23 = sign (1 = negative), bits 22:0 = magnitude.
REQ-007 pi_valid  input  1  pi_in is valid this cycle.
REQ-008 pi_ready  output  1  block accepts a sample this cycle.
REQ-009 dac_sclk  output  1  serial clock to DAC, idle low.
REQ-010 dac_sync_n  output  1  frame select, active low.
REQ-011 dac_sdo  output  1  serial data, MSB first.
REQ-012 busy  output  1  frame in progress (any state except IDLE).
REQ-013 frame_done  output  1  one-cycle pulse when the last bit period of a frame ends.

Function
REQ-014 FSM states: IDLE, SHIFT, GAP; no other reachable states.
REQ-015 pi_ready = 1 only in IDLE; a transfer occurs on a rising edge where pi_valid & pi_ready.
REQ-016 IDLE -> SHIFT on transfer; SHIFT -> GAP after bit 0 period; GAP -> IDLE after GAP_CYC cycles.
REQ-017 Conversion on transfer, registered: mag = 0 -> code 24'h000000 (two's complement) regardless of sign; sign 0 -> {1'b0, mag}; sign 1 -> two's complement negation of {1'b0, mag}.
REQ-018 OFFSET_BIN = 1: transmitted word = converted code with bit 23 inverted.
REQ-019 No saturation needed: full sign-magnitude range (-(2^23-1)..+(2^23-1)) maps losslessly; 24'h800000 (negative zero) treated as zero.
REQ-020 Cycle after transfer: dac_sync_n = 0, dac_sdo = word bit 23, dac_sclk = 0.
REQ-021 Each bit period = 2*CLK_DIV cycles: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; DAC samples on sclk rising edge.
REQ-022 dac_sdo changes only at bit-period boundaries (sclk falling or frame start); stable while sclk high.
REQ-023 24 bit periods per frame, bits 23 down to 0; frame length 48*CLK_DIV cycles of dac_sync_n low.
REQ-024 At end of bit 0 period: dac_sync_n = 1, dac_sclk = 0, dac_sdo = 0, frame_done = 1 for that first GAP cycle only.
REQ-025 pi_valid / pi_in changes while busy are ignored; input word latched only at transfer.
REQ-026 Back-to-back: if pi_valid held high, next transfer occurs on first IDLE cycle; minimum sample-to-sample spacing = 48*CLK_DIV + GAP_CYC + 1 cycles.
REQ-027 All outputs registered; no combinational path from pi_in/pi_valid to any output except pi_ready none (pi_ready is state-decoded).

Reset
REQ-028 rst high at a clk edge forces IDLE from any state, including mid-frame, aborting the frame without completing bits.
REQ-029 Reset values: pi_ready 1 is NOT asserted during rst; after rst deasserts pi_ready = 1; dac_sclk 0, dac_sync_n 1, dac_sdo 0, busy 0, frame_done 0; shift register and counters cleared.
REQ-030 No transfer accepted in a cycle where rst = 1.

Verification (CLK_DIV=2, GAP_CYC=2, OFFSET_BIN=1 unless stated)
REQ-031 pi_in=24'h000005 single transfer -> 24 bits shifted = 24'h800005; dac_sync_n low 96 cycles; frame_done one pulse; pi_ready returns after 2 further GAP cycles.
REQ-032 pi_in=24'h800005 -> word 24'h7FFFFB; with OFFSET_BIN=0 -> 24'hFFFFFB.
REQ-033 pi_in=24'h800000 and 24'h000000 -> both 24'h800000; pi_in=24'h7FFFFF -> 24'hFFFFFF; pi_in=24'hFFFFFF -> 24'h000001.
REQ-034 pi_valid held high with pi_in changing every cycle -> only values present at transfer edges transmitted; transfers spaced exactly 99 cycles apart.
REQ-035 rst asserted 1 cycle at bit 10 of a frame -> next cycle dac_sync_n=1, sclk=0, sdo=0, busy=0, no frame_done; following pi_valid starts a clean full frame.
REQ-036 Bench checks sdo stable throughout every sclk-high interval and exactly 24 sclk rising edges per dac_sync_n low window.

Source files
------------

// File: rtl/pi_dac_tx.sv
// pi_dac_tx: converts a 24-bit sign-magnitude compensation sample into an
// offset-binary or two's-complement word and shifts it MSB first to a
// serial DAC (sclk idle low, DAC samples on sclk rising, sync_n frames).
module pi_dac_tx #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYC    = 2,
    parameter int OFFSET_BIN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] pi_in,
    input  logic        pi_valid,
    output logic        pi_ready,
    output logic        dac_sclk,
    output logic        dac_sync_n,
    output logic        dac_sdo,
    output logic        busy,
    output logic        frame_done
);

    localparam int DW = $clog2(2 * CLK_DIV + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HI   = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic [4:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic [23:0]   sreg;
    logic [23:0]   code;
    logic [23:0]   word;
    logic          take;
    logic          bit_end;
    logic          last_bit;
    logic          gap_end;

    // Ready is a pure state decode, held off while reset is asserted so
    // no transfer can be accepted in a reset cycle.
    assign pi_ready = (state == IDLE) && !rst;
    assign take     = pi_valid && pi_ready;
    assign busy     = (state != IDLE);
    assign bit_end  = (div_cnt == DIV_LAST);
    assign last_bit = (bit_cnt == 5'd0);
    assign gap_end  = (gap_cnt == GAP_LAST);

    // The shift register output is the serial data line, so clearing the
    // register at frame end also drives sdo low for the gap.
    assign dac_sdo  = sreg[23];

    // Sign-magnitude to two's complement; both zeros map to code 0, then
    // optionally flip the MSB for offset binary.
    always_comb begin
        code = '0;
        if (pi_in[22:0] != 23'd0) begin
            if (pi_in[23])
                code = ~{1'b0, pi_in[22:0]} + 24'd1;
            else
                code = {1'b0, pi_in[22:0]};
        end
        word = (OFFSET_BIN != 0) ? {~code[23], code[22:0]} : code;
    end

    // Next-state logic: IDLE -> SHIFT on transfer, SHIFT -> GAP after the
    // bit-0 period, GAP -> IDLE after GAP_CYC cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = SHIFT;
            SHIFT:   if (bit_end && last_bit) state_nxt = GAP;
            GAP:     if (gap_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath: serial timing counters, shift register and framing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg       <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            dac_sclk   <= 1'b0;
            dac_sync_n <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        sreg       <= word;
                        div_cnt    <= '0;
                        bit_cnt    <= 5'd23;
                        dac_sclk   <= 1'b0;
                        dac_sync_n <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_end) begin
                        div_cnt  <= '0;
                        dac_sclk <= 1'b0;
                        if (last_bit) begin
                            sreg       <= '0;
                            gap_cnt    <= '0;
                            dac_sync_n <= 1'b1;
                            frame_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                            sreg    <= {sreg[22:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                        // Second half of the bit period drives sclk high.
                        if (div_cnt == DIV_HI) dac_sclk <= 1'b1;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pi_dac_tx.sv
// Bench for pi_dac_tx: two instances (offset binary and two's complement)
// share the stimulus; a time-since-transfer model predicts every output on
// every cycle, a frame monitor reassembles the shifted words, and directed
// cases pin the reassembled words against hand-computed literals.
module tb_pi_dac_tx;

    localparam int CD      = 2;
    localparam int GC      = 2;
    localparam int PER     = 2 * CD;
    localparam int FRAME   = 24 * PER;
    localparam int SPACING = FRAME + GC + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pi_valid = 1'b0;
    logic [23:0] pi_in = '0;
    logic        ready[2], sclk[2], sync_n[2], sdo[2], busy[2], done[2];

    int nvec = 0;
    int nerr = 0;

    pi_dac_tx #(.CLK_DIV(CD), .GAP_CYC(GC), .OFFSET_BIN(1)) dut1 (
        .clk(clk), .rst(rst), .pi_in(pi_in), .pi_valid(pi_valid),
        .pi_ready(ready[1]), .dac_sclk(sclk[1]), .dac_sync_n(sync_n[1]),
        .dac_sdo(sdo[1]), .busy(busy[1]), .frame_done(done[1]));

    pi_dac_tx #(.CLK_DIV(CD), .GAP_CYC(GC), .OFFSET_BIN(0)) dut0 (
        .clk(clk), .rst(rst), .pi_in(pi_in), .pi_valid(pi_valid),
        .pi_ready(ready[0]), .dac_sclk(sclk[0]), .dac_sync_n(sync_n[0]),
        .dac_sdo(sdo[0]), .busy(busy[0]), .frame_done(done[0]));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Signed value of the sample, wrapped to 24 bits; offset binary adds 2^23.
    function automatic logic [23:0] conv(input logic [23:0] p, input bit ob);
        int          v;
        logic [23:0] c;
        v = int'(p[22:0]);
        if (p[23]) v = -v;
        c = v[23:0];
        if (ob) c = c + 24'h800000;
        return c;
    endfunction

    // Model: t = cycles since the transfer edge (0 = idle).
    int          t = 0;
    logic [23:0] mw[2];
    longint      cyc = 0;
    bit          started = 0;

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (rst) t = 0;
        else if (t == 0) begin
            if (pi_valid) begin
                t = 1;
                mw[1] = conv(pi_in, 1'b1);
                mw[0] = conv(pi_in, 1'b0);
            end
        end else begin
            t++;
            if (t == SPACING) t = 0;
        end
    end

    // Monitor state
    logic [23:0] rxsh[2], rx[2];
    int          lowcnt[2], edges[2];
    bit          abort_f[2];
    logic        psync[2] = '{1'b1, 1'b1};
    logic        psclk[2] = '{1'b0, 1'b0};
    logic        psdo[2]  = '{1'b0, 1'b0};
    bit          spc_on = 0;
    bit          have_fall = 0;
    longint      fall_cyc = 0;
    int          nspc = 0;

    // Per-cycle compare against the model plus frame-level structure checks.
    always @(negedge clk) begin
        if (started) begin
            if (!spc_on) have_fall = 0;
            for (int d = 0; d < 2; d++) begin
                bit in_f;
                int idx;
                in_f = (t >= 1) && (t <= FRAME);
                idx  = in_f ? 23 - (t - 1) / PER : 0;
                chk($sformatf("d%0d ready t=%0d", d, t), ready[d], (t == 0) && !rst);
                chk($sformatf("d%0d sync_n t=%0d", d, t), sync_n[d], !in_f);
                chk($sformatf("d%0d sclk t=%0d", d, t), sclk[d], in_f && (((t - 1) % PER) >= CD));
                chk($sformatf("d%0d sdo t=%0d", d, t), sdo[d], in_f ? mw[d][idx] : 1'b0);
                chk($sformatf("d%0d busy t=%0d", d, t), busy[d], t != 0);
                chk($sformatf("d%0d frame_done t=%0d", d, t), done[d], t == FRAME + 1);

                if (sclk[d] && psclk[d])
                    chk($sformatf("d%0d sdo_stable_sclk_high", d), sdo[d], psdo[d]);

                if (psync[d] && !sync_n[d]) begin
                    lowcnt[d] = 0; edges[d] = 0; abort_f[d] = 0; rxsh[d] = '0;
                    if (d == 1 && spc_on) begin
                        if (have_fall) begin
                            chk("b2b_spacing", 32'(cyc - fall_cyc), SPACING);
                            nspc++;
                        end
                        fall_cyc = cyc;
                        have_fall = 1;
                    end
                end
                if (!sync_n[d]) begin
                    lowcnt[d]++;
                    if (rst) abort_f[d] = 1;
                    if (sclk[d] && !psclk[d]) begin
                        rxsh[d] = {rxsh[d][22:0], sdo[d]};
                        edges[d]++;
                    end
                end
                if (sync_n[d] && !psync[d]) begin
                    if (!abort_f[d]) begin
                        chk($sformatf("d%0d sclk_rises_per_frame", d), edges[d], 24);
                        chk($sformatf("d%0d sync_low_cycles", d), lowcnt[d], FRAME);
                        rx[d] = rxsh[d];
                    end
                    abort_f[d] = 0;
                end
                psync[d] = sync_n[d];
                psclk[d] = sclk[d];
                psdo[d]  = sdo[d];
            end
        end
    end

    task automatic send(input logic [23:0] v);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        pi_in = v; pi_valid = 1'b1;
        for (int i = 0; i < 4 * SPACING; i++) begin
            @(negedge clk);
            if (ready[1]) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        // Activity on the inputs mid-frame must be ignored.
        repeat (3) begin
            @(posedge clk); #1;
            pi_in = 24'($urandom); pi_valid = 1'b1;
        end
        @(posedge clk); #1;
        pi_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 4 * SPACING; i++) begin
            @(negedge clk);
            if (done[1]) begin ok = 1; break; end
        end
        if (!ok) chk("frame_done_timeout", 0, 1);
        ok = 0;
        for (int i = 0; i < 4 * SPACING; i++) begin
            @(negedge clk);
            if (ready[1]) begin ok = 1; break; end
        end
        if (!ok) chk("ready_return_timeout", 0, 1);
        @(negedge clk);
    endtask

    logic [23:0] vin[7] = '{24'h000005, 24'h800005, 24'h800000, 24'h000000,
                            24'h7FFFFF, 24'hFFFFFF, 24'h123456};
    logic [23:0] ve1[7] = '{24'h800005, 24'h7FFFFB, 24'h800000, 24'h800000,
                            24'hFFFFFF, 24'h000001, 24'h923456};
    logic [23:0] ve0[7] = '{24'h000005, 24'hFFFFFB, 24'h000000, 24'h000000,
                            24'h7FFFFF, 24'h800001, 24'h123456};

    initial begin
        bit ok;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset ready", ready[1], 1);
        chk("post_reset sync_n", sync_n[1], 1);
        chk("post_reset busy", busy[1], 0);

        // Conversion table, both output codings
        for (int k = 0; k < 7; k++) begin
            send(vin[k]);
            wait_done();
            chk($sformatf("word_ob1 in=%06h", vin[k]), rx[1], ve1[k]);
            chk($sformatf("word_ob0 in=%06h", vin[k]), rx[0], ve0[k]);
        end

        // Back-to-back with pi_in changing every cycle
        spc_on = 1;
        @(posedge clk); #1;
        pi_valid = 1'b1;
        for (int i = 0; i < 3 * SPACING + 5; i++) begin
            pi_in = 24'($urandom);
            @(posedge clk); #1;
        end
        pi_valid = 1'b0;
        wait_done();
        spc_on = 0;
        chk("b2b_spacing_checks_seen", 32'(nspc >= 2), 1);

        // Reset mid-frame at bit 10
        send(24'h0F0F0F);
        ok = 0;
        for (int i = 0; i < 2 * SPACING; i++) begin
            @(negedge clk);
            if (t == 1 + (23 - 10) * PER) begin ok = 1; break; end
        end
        if (!ok) chk("bit10_timeout", 0, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort sync_n", sync_n[1], 1);
        chk("abort sclk", sclk[1], 0);
        chk("abort sdo", sdo[1], 0);
        chk("abort busy", busy[1], 0);
        chk("abort frame_done", done[1], 0);
        repeat (5) @(negedge clk);
        send(24'h800005);
        wait_done();
        chk("post_abort word_ob1", rx[1], 24'h7FFFFB);
        chk("post_abort word_ob0", rx[0], 24'hFFFFFB);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        nerr++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
